// File: rtl/voting_pkg.sv
// Shared state type and button-vector helpers
// for the parametrised voting machine.
package voting_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    ACK,
    WAIT_REL
  } state_t;

  function automatic int unsigned popcnt(
    input logic [31:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++)
      n += 32'(v[i]);
    return n;
  endfunction

  function automatic logic onehot(
    input logic [31:0] v
  );
    return popcnt(v) == 1;
  endfunction

endpackage

// File: rtl/vote_hold_timer.sv
// Cycle counter with clear/enable; done strobes
// on the MAX-th consecutive enabled cycle.
module vote_hold_timer #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  assign done = en && (cnt == W'(MAX - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/voting_machine_param.sv
// N-candidate voting machine: hold-to-vote,
// saturating tallies, running total, LED readout.
module voting_machine_param
  import voting_pkg::*;
#(
  parameter int unsigned N_CAND   = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned HOLD_CYC = 100_000_000,
  parameter int unsigned ACK_CYC  = 10_000_000,
  parameter int unsigned LED_W    = 8,
  localparam int TOT_W = CNT_W + $clog2(N_CAND)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [N_CAND-1:0] btn,
  output logic [LED_W-1:0]  led,
  output logic              vote_pulse,
  output logic              reject_pulse,
  output logic [TOT_W-1:0]  total
);

  localparam int IW = $clog2(N_CAND);

  state_t state, nstate;

  logic [CNT_W-1:0]  tally [N_CAND];
  logic [IW-1:0]     idx, low, vidx;
  logic [N_CAND-1:0] mask;
  logic [LED_W-1:0]  sel;
  logic one, multi, other, sat;
  logic hold_en, hold_done;
  logic ack_en, ack_done;
  logic vote, rej;

  assign one   = onehot(32'(btn));
  assign multi = popcnt(32'(btn)) > 1;
  assign mask  = N_CAND'(1) << idx;
  assign other = |(btn & ~mask);

  always_comb begin
    low = '0;
    for (int i = N_CAND - 1; i >= 0; i--)
      if (btn[i]) low = IW'(i);
  end

  assign vidx = (state == IDLE) ? low : idx;
  assign sat  = &tally[vidx];

  // Zero-extend or truncate the selected tally
  always_comb begin
    sel = '0;
    for (int i = 0; i < LED_W && i < CNT_W; i++)
      sel[i] = tally[low][i];
  end

  assign hold_en = !mode &&
    ((state == IDLE && one) ||
     (state == HOLD && !other && btn[idx]));
  assign ack_en = !mode && state == ACK;

  vote_hold_timer #(
    .MAX (HOLD_CYC)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clr  (!hold_en),
    .en   (hold_en),
    .done (hold_done)
  );

  vote_hold_timer #(
    .MAX (ACK_CYC)
  ) u_ack (
    .clk  (clk),
    .rst  (rst),
    .clr  (!ack_en),
    .en   (ack_en),
    .done (ack_done)
  );

  always_comb begin
    nstate = state;
    vote   = 1'b0;
    rej    = 1'b0;
    if (mode) begin
      nstate = WAIT_REL;
    end else begin
      unique case (state)
        IDLE: begin
          if (one) begin
            nstate = HOLD;
          end else if (multi) begin
            rej    = 1'b1;
            nstate = WAIT_REL;
          end
        end
        HOLD: begin
          if (other) begin
            rej    = 1'b1;
            nstate = WAIT_REL;
          end else if (!btn[idx]) begin
            nstate = IDLE;
          end
        end
        ACK: begin
          if (ack_done) nstate = WAIT_REL;
        end
        WAIT_REL: begin
          if (btn == '0) nstate = IDLE;
        end
        default: nstate = WAIT_REL;
      endcase
      if (hold_done) begin
        vote   = 1'b1;
        nstate = ACK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_REL;
      idx          <= '0;
      total        <= '0;
      led          <= '0;
      vote_pulse   <= 1'b0;
      reject_pulse <= 1'b0;
      for (int i = 0; i < N_CAND; i++)
        tally[i] <= '0;
    end else begin
      state        <= nstate;
      vote_pulse   <= vote && !sat;
      reject_pulse <= rej || (vote && sat);
      if (state == IDLE && one)
        idx <= low;
      if (vote && !sat) begin
        tally[vidx] <= tally[vidx] + CNT_W'(1);
        total       <= total + TOT_W'(1);
      end
      if (mode) begin
        if (|btn) led <= sel;
      end else begin
        led <= (nstate == ACK) ? '1 : '0;
      end
    end
  end

endmodule

// File: tb/tb_voting_machine_param.sv
// Self-checking bench for voting_machine_param.
// Scenario tasks plus a randomized session model.
module tb_voting_machine_param;

  localparam int HC = 5;
  localparam int AC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mode, mode2;
  logic [3:0] btn, btn2;
  logic [7:0] led, led2;
  logic       vp, rp, vp2, rp2;
  logic [9:0] total;
  logic [3:0] total2;

  int checks = 0;
  int errors = 0;
  int exp_tally [4];
  int exp_total;

  voting_machine_param #(
    .N_CAND(4), .CNT_W(8), .HOLD_CYC(HC),
    .ACK_CYC(AC), .LED_W(8)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .btn(btn), .led(led), .vote_pulse(vp),
    .reject_pulse(rp), .total(total)
  );

  voting_machine_param #(
    .N_CAND(4), .CNT_W(2), .HOLD_CYC(HC),
    .ACK_CYC(AC), .LED_W(8)
  ) dut2 (
    .clk(clk), .rst(rst), .mode(mode2),
    .btn(btn2), .led(led2), .vote_pulse(vp2),
    .reject_pulse(rp2), .total(total2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; mode2 = 1'b0;
    btn = '0; btn2 = '0;
    ticks(10);
    checks++;
    if (led !== 8'h00 || total !== 10'd0) begin
      errors++;
      $display("FAIL reset led=%h total=%0d want 00/0",
               led, total);
    end
    checks++;
    if (vp !== 1'b0 || rp !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses vp=%b rp=%b want 0/0",
               vp, rp);
    end
    checks++;
    if (total2 !== 4'd0 || led2 !== 8'h00) begin
      errors++;
      $display("FAIL reset2 total=%0d led=%h want 0/00",
               total2, led2);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_vote();
    btn = 4'b0001;
    ticks(HC - 1);
    checks++;
    if (vp !== 1'b0 || total !== 10'd0) begin
      errors++;
      $display("FAIL early_vote vp=%b total=%0d want 0/0",
               vp, total);
    end
    tick();
    checks++;
    if (vp !== 1'b1 || rp !== 1'b0) begin
      errors++;
      $display("FAIL vote_pulse vp=%b rp=%b want 1/0",
               vp, rp);
    end
    checks++;
    if (total !== 10'd1 || led !== 8'hff) begin
      errors++;
      $display("FAIL vote_total total=%0d led=%h want 1/ff",
               total, led);
    end
    btn = '0;
    for (int i = 0; i < AC - 1; i++) begin
      tick();
      checks++;
      if (led !== 8'hff || vp !== 1'b0) begin
        errors++;
        $display("FAIL ack_led c%0d led=%h vp=%b want ff/0",
                 i, led, vp);
      end
    end
    tick();
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL ack_end led=%h want 00", led);
    end
    ticks(2);
  endtask

  task automatic test_short_press();
    int nv, nr;
    nv = 0; nr = 0;
    btn = 4'b0010;
    for (int i = 0; i < HC - 1; i++) begin
      tick(); nv += int'(vp); nr += int'(rp);
    end
    btn = '0;
    for (int i = 0; i < 8; i++) begin
      tick(); nv += int'(vp); nr += int'(rp);
    end
    checks++;
    if (nv != 0 || nr != 0 || total !== 10'd1) begin
      errors++;
      $display("FAIL short_press v=%0d r=%0d total=%0d want 0/0/1",
               nv, nr, total);
    end
  endtask

  task automatic test_long_press();
    int nv, nr;
    nv = 0; nr = 0;
    btn = 4'b0001;
    for (int i = 0; i < 50; i++) begin
      tick(); nv += int'(vp); nr += int'(rp);
    end
    btn = '0;
    ticks(2);
    checks++;
    if (nv != 1 || nr != 0 || total !== 10'd2) begin
      errors++;
      $display("FAIL long_press v=%0d r=%0d total=%0d want 1/0/2",
               nv, nr, total);
    end
    btn = 4'b0101;
    tick();
    checks++;
    if (rp !== 1'b1 || vp !== 1'b0) begin
      errors++;
      $display("FAIL multi_press rp=%b vp=%b want 1/0", rp, vp);
    end
    nv = 0; nr = 0;
    for (int i = 0; i < 8; i++) begin
      tick(); nv += int'(vp); nr += int'(rp);
    end
    btn = '0;
    ticks(2);
    checks++;
    if (nv != 0 || nr != 0 || total !== 10'd2) begin
      errors++;
      $display("FAIL multi_hold v=%0d r=%0d total=%0d want 0/0/2",
               nv, nr, total);
    end
  endtask

  task automatic test_result_mode();
    mode = 1'b1;
    tick();
    btn = 4'b0001; tick();
    checks++;
    if (led !== 8'h02) begin
      errors++;
      $display("FAIL result_btn0 led=%h want 02", led);
    end
    btn = 4'b1000; tick();
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL result_btn3 led=%h want 00", led);
    end
    btn = '0; ticks(2);
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL result_hold0 led=%h want 00", led);
    end
    btn = 4'b1011; tick();
    btn = '0; ticks(3);
    checks++;
    if (led !== 8'h02) begin
      errors++;
      $display("FAIL result_lowest led=%h want 02", led);
    end
    btn = 4'b0001; ticks(20);
    checks++;
    if (vp !== 1'b0 || total !== 10'd2) begin
      errors++;
      $display("FAIL result_novote vp=%b total=%0d want 0/2",
               vp, total);
    end
    mode = 1'b0; btn = '0;
    ticks(2);
    checks++;
    if (led !== 8'h00) begin
      errors++;
      $display("FAIL result_exit led=%h want 00", led);
    end
  endtask

  task automatic test_saturate();
    int nv, nr;
    for (int p = 0; p < 4; p++) begin
      nv = 0; nr = 0;
      btn2 = 4'b0100;
      for (int i = 0; i < HC; i++) begin
        tick(); nv += int'(vp2); nr += int'(rp2);
      end
      btn2 = '0;
      for (int i = 0; i < AC + 2; i++) begin
        tick(); nv += int'(vp2); nr += int'(rp2);
      end
      checks++;
      if (nv != int'(p < 3) || nr != int'(p == 3)) begin
        errors++;
        $display("FAIL sat_press%0d v=%0d r=%0d want %0d/%0d",
                 p, nv, nr, int'(p < 3), int'(p == 3));
      end
    end
    checks++;
    if (total2 !== 4'd3) begin
      errors++;
      $display("FAIL sat_total total=%0d want 3", total2);
    end
    mode2 = 1'b1;
    tick();
    btn2 = 4'b0100; tick();
    checks++;
    if (led2 !== 8'h03) begin
      errors++;
      $display("FAIL sat_tally led=%h want 03", led2);
    end
    mode2 = 1'b0; btn2 = '0;
    ticks(2);
  endtask

  task automatic test_reset_hold();
    int nv;
    rst = 1'b1; btn = 4'b0001;
    ticks(3);
    checks++;
    if (total !== 10'd0 || led !== 8'h00) begin
      errors++;
      $display("FAIL rst_clear total=%0d led=%h want 0/00",
               total, led);
    end
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); nv += int'(vp);
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL held_thru_rst votes=%0d want 0", nv);
    end
    btn = '0; tick();
    btn = 4'b0001; ticks(HC);
    checks++;
    if (vp !== 1'b1 || total !== 10'd1) begin
      errors++;
      $display("FAIL repress vp=%b total=%0d want 1/1",
               vp, total);
    end
    btn = '0; ticks(AC + 2);
    btn = 4'b0010; ticks(3);
    rst = 1'b1; tick();
    checks++;
    if (total !== 10'd0 || led !== 8'h00 ||
        vp !== 1'b0 || rp !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid total=%0d led=%h vp=%b rp=%b want 0",
               total, led, vp, rp);
    end
    tick();
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); nv += int'(vp);
    end
    btn = '0; ticks(2);
    checks++;
    if (nv != 0 || total !== 10'd0) begin
      errors++;
      $display("FAIL rst_mid_vote votes=%0d total=%0d want 0/0",
               nv, total);
    end
  endtask

  // Each session: press pattern for len cycles,
  // then release long enough to get back to idle.
  task automatic test_random();
    int c, o, len, k, r, nv, nr;
    bit multi, intf, prev, ev, er;
    logic [3:0] p;
    for (int i = 0; i < 4; i++) exp_tally[i] = 0;
    exp_total = 0;
    for (int s = 0; s < 40; s++) begin
      c = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 9));
      r = int'($urandom_range(0, 9));
      multi = (r < 2);
      intf = (r >= 2 && r < 4);
      p = 4'(1 << c);
      o = (c + int'($urandom_range(1, 3))) % 4;
      k = int'($urandom_range(2, HC));
      if (multi) begin
        p = p | 4'(1 << o);
        len = int'($urandom_range(1, 4));
      end
      nv = 0; nr = 0; prev = 1'b0;
      for (int t = 1; t <= len + AC + 3; t++) begin
        if (t > len) btn = '0;
        else if (intf && t >= k) btn = p | 4'(1 << o);
        else btn = p;
        tick();
        checks++;
        if (vp && rp) begin
          errors++;
          $display("FAIL rnd_overlap s%0d t%0d vp=1 rp=1", s, t);
        end
        checks++;
        if ((vp || rp) && prev) begin
          errors++;
          $display("FAIL rnd_width s%0d t%0d pulse >1 cycle",
                   s, t);
        end
        prev = vp || rp;
        nv += int'(vp);
        nr += int'(rp);
      end
      ev = !multi && len >= HC && !(intf && k <= len);
      er = multi || (intf && k <= len);
      if (ev) begin
        exp_tally[c]++;
        exp_total++;
      end
      checks++;
      if (nv != int'(ev) || nr != int'(er)) begin
        errors++;
        $display("FAIL rnd_pulses s%0d v=%0d r=%0d want %0d/%0d",
                 s, nv, nr, int'(ev), int'(er));
      end
      checks++;
      if (total !== 10'(exp_total)) begin
        errors++;
        $display("FAIL rnd_total s%0d got %0d want %0d",
                 s, total, exp_total);
      end
    end
    mode = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      btn = 4'(1 << i);
      tick();
      checks++;
      if (led !== 8'(exp_tally[i])) begin
        errors++;
        $display("FAIL rnd_tally%0d got %0d want %0d",
                 i, led, exp_tally[i]);
      end
    end
    mode = 1'b0; btn = '0;
    ticks(2);
  endtask

  initial begin
    test_reset();
    test_single_vote();
    test_short_press();
    test_long_press();
    test_result_mode();
    test_saturate();
    test_reset_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
